// File: rtl/sipo_frame_ctrl_pkg.sv
// Shared definitions for the serial-in/parallel-out frame controller.
// Optional build macro: SIPO_FRAME_PARITY_EN (adds a trailing even-parity bit per frame).
package sipo_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Number of serial bits that make up one frame.
    function automatic int frame_bits(input int width);
`ifdef SIPO_FRAME_PARITY_EN
        return width + 1;
`else
        return width;
`endif
    endfunction

endpackage

// File: rtl/sipo_frame_ctrl_if.sv
// Serial-input and parallel-output bus of the frame controller.
// master is the controller's view; slave is the source/consumer side.
// Optional build macro: SIPO_FRAME_PARITY_EN (adds par_err).
interface sipo_frame_ctrl_if
    import sipo_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             s_in;
    logic             s_valid;
    logic [WIDTH-1:0] p_data;
    logic             p_valid;
    logic             p_ready;
`ifdef SIPO_FRAME_PARITY_EN
    logic             par_err;
`endif

    modport master (
        input  s_in, s_valid, p_ready,
`ifdef SIPO_FRAME_PARITY_EN
        output par_err,
`endif
        output p_data, p_valid
    );

    modport slave (
        output s_in, s_valid, p_ready,
`ifdef SIPO_FRAME_PARITY_EN
        input  par_err,
`endif
        input  p_data, p_valid
    );
endinterface

// File: rtl/sipo_frame_ctrl_shreg.sv
// WIDTH-bit shift register with enable, synchronous clear and selectable direction.
// When clear and enable coincide, the incoming bit lands in an otherwise empty register.
module sipo_shreg
    import sipo_ctrl_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] shifted;

    // Select the value being shifted (empty on clear) and insert the new bit at the proper end.
    always_comb begin
        base = clr ? '0 : q;
        if (MSB_FIRST)
            shifted = (base << 1) | WIDTH'(d);
        else
            shifted = (base >> 1) | (WIDTH'(d) << (WIDTH - 1));
    end

    // Register update: shift on enable, otherwise clear or hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= '0;
        else if (en)
            q <= shifted;
        else if (clr)
            q <= '0;
    end
endmodule

// File: rtl/sipo_frame_ctrl.sv
// Frame controller: counts strobed serial bits into words, presents them on a
// valid/ready port and flags words dropped under backpressure (sticky overrun).
// Optional build macro: SIPO_FRAME_PARITY_EN (frame gains an even-parity bit, par_err output).
module sipo_frame_ctrl
    import sipo_ctrl_pkg::*;
#(
    parameter int  WIDTH     = DEFAULT_WIDTH,
    parameter bit  MSB_FIRST = 1'b1,
    localparam int CNT_W     = $clog2(frame_bits(WIDTH) + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             ovr_clr,
    output logic             busy,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             overrun,
    sipo_frame_ctrl_if.master bus
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(frame_bits(WIDTH) - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] p_data_q;
    logic             p_valid_q;
    logic             complete;
    logic             sh_en;
    logic             load;
    logic             drop;

    // Frame completion, shift enable and output load/drop decisions.
    always_comb begin
        complete = (state == ST_SHIFT) && !start && bus.s_valid && (bit_cnt == LAST);
`ifdef SIPO_FRAME_PARITY_EN
        // The parity bit is checked, never stored, so the register stops at WIDTH data bits.
        sh_en = bus.s_valid && (start || (state == ST_SHIFT && bit_cnt != LAST));
        word  = sreg;
`else
        sh_en = bus.s_valid && (start || state == ST_SHIFT);
        // The last data bit is merged combinationally so the word loads in the same edge.
        if (MSB_FIRST)
            word = (sreg << 1) | WIDTH'(bus.s_in);
        else
            word = (sreg >> 1) | (WIDTH'(bus.s_in) << (WIDTH - 1));
`endif
        load = complete && (!p_valid_q || bus.p_ready);
        drop = complete && p_valid_q && !bus.p_ready;
    end

    sipo_shreg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shreg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (sh_en),
        .clr   (start),
        .d     (bus.s_in),
        .q     (sreg)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    // FSM next state: start always (re)enters SHIFT; completion returns to IDLE.
    always_comb begin
        state_next = state;
        if (start)
            state_next = ST_SHIFT;
        else if (complete)
            state_next = ST_IDLE;
    end

    // FSM outputs.
    always_comb begin
        busy = (state == ST_SHIFT);
    end

    // Bit counter: restart counts the start-cycle bit, completion rewinds to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            bit_cnt <= '0;
        else if (start)
            bit_cnt <= CNT_W'(bus.s_valid);
        else if (complete)
            bit_cnt <= '0;
        else if (state == ST_SHIFT && bus.s_valid)
            bit_cnt <= bit_cnt + CNT_W'(1);
    end

    // Output word register: load on completion, release on handshake; data holds while valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_data_q  <= '0;
            p_valid_q <= 1'b0;
        end else if (load) begin
            p_data_q  <= word;
            p_valid_q <= 1'b1;
        end else if (p_valid_q && bus.p_ready) begin
            p_valid_q <= 1'b0;
        end
    end

    // Sticky overrun: a dropped word sets it, and setting wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            overrun <= 1'b0;
        else if (drop)
            overrun <= 1'b1;
        else if (ovr_clr)
            overrun <= 1'b0;
    end

`ifdef SIPO_FRAME_PARITY_EN
    logic par_err_q;

    // Parity error travels with the word: XOR over data bits and the received parity bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            par_err_q <= 1'b0;
        else if (load)
            par_err_q <= (^sreg) ^ bus.s_in;
    end

    assign bus.par_err = par_err_q;
`endif

    assign bus.p_data  = p_data_q;
    assign bus.p_valid = p_valid_q;
endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Directed bench for sipo_frame_ctrl: per-cycle vector table plus hand-written
// sequences for asynchronous reset mid-frame and simultaneous overrun/clear.
module tb_sipo_frame_ctrl;
    import sipo_ctrl_pkg::*;

    localparam int WIDTH     = 4;
    localparam bit MSB_FIRST = 1'b1;
`ifdef SIPO_FRAME_PARITY_EN
    localparam int CNT_W = $clog2(WIDTH + 2);
`else
    localparam int CNT_W = $clog2(WIDTH + 1);
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             ovr_clr;
    logic             busy;
    logic [CNT_W-1:0] bit_cnt;
    logic             overrun;

    int errors = 0;
    int checks = 0;

    sipo_frame_ctrl_if #(.WIDTH(WIDTH)) bus ();

    sipo_frame_ctrl #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .ovr_clr (ovr_clr),
        .busy    (busy),
        .bit_cnt (bit_cnt),
        .overrun (overrun),
        .bus     (bus.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       st, sv, si, pr, oc;
        logic       pv;
        logic [3:0] pd;   // written as received order, first bit leftmost
        logic       bsy;
        int         cnt;
        logic       ovr;
    } vec_t;

    vec_t vecs[$];

    // Map a word written in arrival order to the expected p_data for the configured direction.
    function automatic logic [3:0] exp_w(input logic [3:0] w);
        return MSB_FIRST ? w : {w[0], w[1], w[2], w[3]};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic st, sv, si, pr, oc, pv, input logic [3:0] pd,
                       input logic bsy, input int cnt, input logic ovr);
        vec_t v;
        v.st = st; v.sv = sv; v.si = si; v.pr = pr; v.oc = oc;
        v.pv = pv; v.pd = pd; v.bsy = bsy; v.cnt = cnt; v.ovr = ovr;
        vecs.push_back(v);
    endtask

    // Drive one cycle of inputs at the falling edge, then sample just after the rising edge.
    task automatic step(input logic st, sv, si, pr, oc);
        @(negedge clk);
        start       = st;
        bus.s_valid = sv;
        bus.s_in    = si;
        bus.p_ready = pr;
        ovr_clr     = oc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b1; ovr_clr = 1'b0;
        bus.s_valid = 1'b1; bus.s_in = 1'b1; bus.p_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_p_data",  int'(bus.p_data), 0);
        chk("rst_p_valid", int'(bus.p_valid), 0);
        chk("rst_busy",    int'(busy), 0);
        chk("rst_bit_cnt", int'(bit_cnt), 0);
        chk("rst_overrun", int'(overrun), 0);
        @(negedge clk);
        rst_n = 1'b1; start = 1'b0; bus.s_valid = 1'b0; bus.s_in = 1'b0; bus.p_ready = 1'b1;

`ifdef SIPO_FRAME_PARITY_EN
        chk("par_rst", int'(bus.par_err), 0);
        // Data 1010, parity 1: odd overall -> error.
        step(1, 1, 1, 1, 0); chk("par1_cnt1", int'(bit_cnt), 1);
        step(0, 1, 0, 1, 0);
        step(0, 1, 1, 1, 0);
        step(0, 1, 0, 1, 0); chk("par1_cnt4", int'(bit_cnt), 4);
        chk("par1_busy4", int'(busy), 1);
        step(0, 1, 1, 1, 0);
        chk("par1_pv",  int'(bus.p_valid), 1);
        chk("par1_pd",  int'(bus.p_data), int'(exp_w(4'b1010)));
        chk("par1_err", int'(bus.par_err), 1);
        chk("par1_cnt", int'(bit_cnt), 0);
        // Data 1010, parity 0: even overall -> no error.
        step(1, 1, 1, 1, 0);
        step(0, 1, 0, 1, 0);
        step(0, 1, 1, 1, 0);
        step(0, 1, 0, 1, 0);
        step(0, 1, 0, 1, 0);
        chk("par0_pv",  int'(bus.p_valid), 1);
        chk("par0_pd",  int'(bus.p_data), int'(exp_w(4'b1010)));
        chk("par0_err", int'(bus.par_err), 0);
`else
        //  st sv si pr oc | pv pd       bsy cnt ovr
        // back-to-back 1010
        add(1, 1, 1, 1, 0,  0, 4'b0000, 1, 1, 0);
        add(0, 1, 0, 1, 0,  0, 4'b0000, 1, 2, 0);
        add(0, 1, 1, 1, 0,  0, 4'b0000, 1, 3, 0);
        add(0, 1, 0, 1, 0,  1, 4'b1010, 0, 0, 0);
        add(0, 0, 0, 1, 0,  0, 4'b1010, 0, 0, 0);
        // gapped strobe 1100
        add(1, 1, 1, 1, 0,  0, 4'b1010, 1, 1, 0);
        add(0, 0, 0, 1, 0,  0, 4'b1010, 1, 1, 0);
        add(0, 0, 1, 1, 0,  0, 4'b1010, 1, 1, 0);
        add(0, 1, 1, 1, 0,  0, 4'b1010, 1, 2, 0);
        add(0, 0, 1, 1, 0,  0, 4'b1010, 1, 2, 0);
        add(0, 0, 0, 1, 0,  0, 4'b1010, 1, 2, 0);
        add(0, 1, 0, 1, 0,  0, 4'b1010, 1, 3, 0);
        add(0, 0, 1, 1, 0,  0, 4'b1010, 1, 3, 0);
        add(0, 0, 1, 1, 0,  0, 4'b1010, 1, 3, 0);
        add(0, 1, 0, 1, 0,  1, 4'b1100, 0, 0, 0);
        add(0, 0, 0, 1, 0,  0, 4'b1100, 0, 0, 0);
        // backpressure: 1111 loads, 0101 dropped
        add(1, 1, 1, 0, 0,  0, 4'b1100, 1, 1, 0);
        add(0, 1, 1, 0, 0,  0, 4'b1100, 1, 2, 0);
        add(0, 1, 1, 0, 0,  0, 4'b1100, 1, 3, 0);
        add(0, 1, 1, 0, 0,  1, 4'b1111, 0, 0, 0);
        add(1, 1, 0, 0, 0,  1, 4'b1111, 1, 1, 0);
        add(0, 1, 1, 0, 0,  1, 4'b1111, 1, 2, 0);
        add(0, 1, 0, 0, 0,  1, 4'b1111, 1, 3, 0);
        add(0, 1, 1, 0, 0,  1, 4'b1111, 0, 0, 1);
        add(0, 0, 0, 1, 0,  0, 4'b1111, 0, 0, 1);
        add(0, 0, 0, 1, 1,  0, 4'b1111, 0, 0, 0);
        // restart after two bits, then 0101
        add(1, 1, 1, 1, 0,  0, 4'b1111, 1, 1, 0);
        add(0, 1, 1, 1, 0,  0, 4'b1111, 1, 2, 0);
        add(1, 1, 0, 1, 0,  0, 4'b1111, 1, 1, 0);
        add(0, 1, 1, 1, 0,  0, 4'b1111, 1, 2, 0);
        add(0, 1, 0, 1, 0,  0, 4'b1111, 1, 3, 0);
        add(0, 1, 1, 1, 0,  1, 4'b0101, 0, 0, 0);
        add(0, 0, 0, 1, 0,  0, 4'b0101, 0, 0, 0);
        // s_valid ignored in IDLE; start without a bit; restart without a bit
        add(0, 1, 1, 1, 0,  0, 4'b0101, 0, 0, 0);
        add(1, 0, 0, 1, 0,  0, 4'b0101, 1, 0, 0);
        add(1, 0, 0, 1, 0,  0, 4'b0101, 1, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].st, vecs[i].sv, vecs[i].si, vecs[i].pr, vecs[i].oc);
            chk($sformatf("v%0d_p_valid", i), int'(bus.p_valid), int'(vecs[i].pv));
            chk($sformatf("v%0d_p_data", i),  int'(bus.p_data), int'(exp_w(vecs[i].pd)));
            chk($sformatf("v%0d_busy", i),    int'(busy), int'(vecs[i].bsy));
            chk($sformatf("v%0d_bit_cnt", i), int'(bit_cnt), vecs[i].cnt);
            chk($sformatf("v%0d_overrun", i), int'(overrun), int'(vecs[i].ovr));
        end

        // Mid-frame asynchronous reset after two bits.
        step(0, 1, 1, 1, 0);
        step(0, 1, 1, 1, 0);
        chk("mid_cnt_before", int'(bit_cnt), 2);
        @(negedge clk);
        start = 1'b0; bus.s_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_cnt",  int'(bit_cnt), 0);
        chk("mid_rst_busy", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 1, 0, 1, 0);
        step(0, 1, 0, 1, 0);
        step(0, 1, 1, 1, 0);
        step(0, 1, 1, 1, 0);
        chk("post_rst_pv", int'(bus.p_valid), 1);
        chk("post_rst_pd", int'(bus.p_data), int'(exp_w(4'b0011)));

        // Overrun set and clear in the same cycle: set wins.
        step(1, 1, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        step(0, 1, 1, 0, 1);
        chk("setwin_ovr", int'(overrun), 1);
        chk("setwin_pd",  int'(bus.p_data), int'(exp_w(4'b0011)));
        chk("setwin_pv",  int'(bus.p_valid), 1);
        step(0, 0, 0, 0, 1);
        chk("clr_ovr", int'(overrun), 0);
        chk("clr_pv",  int'(bus.p_valid), 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
